lua_avalon_mem_master: RTL and testbench

- Memory-port master for the LuaCPU core, directly upstream of the SDRAM controller slave inside soc_system.
- Converts the core's single-outstanding request/response handshake into Avalon-MM pipelined master cycles: waitrequest stall, variable-latency readdatavalid.
- One 32-bit word per transaction; word address in, byte address out.

---
 rtl/lua_mem_pkg.sv | 16 +
 rtl/lua_avalon_mem_master.sv | 123 ++++++++++++
 tb/tb_lua_avalon_mem_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lua_mem_pkg.sv
// lua_mem_pkg: shared types and constants for the LuaCPU memory port.
package lua_mem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} state_t;
  typedef struct packed {
    logic write;
    logic [BE_W-1:0] be;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
  typedef struct packed {
    logic err;
    logic [DATA_W-1:0] rdata;
  } mem_rsp_t;
endpackage

// File: rtl/lua_avalon_mem_master.sv
// lua_avalon_mem_master: single-outstanding core request/response to Avalon-MM master.
// Optional watchdog with stale-beat discard is enabled by LUA_AVM_TIMEOUT_EN.
module lua_avalon_mem_master
  import lua_mem_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);
  state_t state;
  logic take;
`ifdef LUA_AVM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt;
  logic stale, err, tmo;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // a beat owed to a timed-out read must never be taken as the next read's data
  assign take = avm_readdatavalid && !stale;
`else
  assign take = avm_readdatavalid;
  assign rsp_err = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      avm_address <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= '0;
      avm_byteenable <= '0;
`ifdef LUA_AVM_TIMEOUT_EN
      cnt <= '0;
      stale <= 1'b0;
      err <= 1'b0;
      rsp_err <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef LUA_AVM_TIMEOUT_EN
      rsp_err <= 1'b0;
      cnt <= cnt + 1'b1;
      if (avm_readdatavalid && stale) stale <= 1'b0;
`endif
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            avm_read <= !req_write;
            avm_write <= req_write;
            avm_address <= {req_addr, 2'b00};
            avm_writedata <= req_wdata;
            avm_byteenable <= req_write ? req_be : 4'hF;
            state <= CMD;
`ifdef LUA_AVM_TIMEOUT_EN
            cnt <= '0;
            err <= 1'b0;
`endif
          end
        end
        CMD:
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            avm_write <= 1'b0;
            state <= avm_write ? RESP : RDWAIT;
`ifdef LUA_AVM_TIMEOUT_EN
            cnt <= '0;
`endif
          end
`ifdef LUA_AVM_TIMEOUT_EN
          else if (tmo) begin
            avm_read <= 1'b0;
            avm_write <= 1'b0;
            err <= 1'b1;
            rsp_rdata <= TIMEOUT_RDATA;
            state <= RESP;
          end
`endif
        RDWAIT:
          if (take) begin
            rsp_rdata <= avm_readdata;
            state <= RESP;
          end
`ifdef LUA_AVM_TIMEOUT_EN
          else if (tmo) begin
            stale <= 1'b1;
            err <= 1'b1;
            rsp_rdata <= TIMEOUT_RDATA;
            state <= RESP;
          end
`endif
        RESP: begin
          rsp_valid <= 1'b1;
`ifdef LUA_AVM_TIMEOUT_EN
          rsp_err <= err;
`endif
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_lua_avalon_mem_master.sv
// tb_lua_avalon_mem_master: scoreboard bench with an Avalon slave model and response monitor.
module tb_lua_avalon_mem_master;
`ifdef LUA_AVM_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  logic clk_clk = 0, reset_reset_n = 0;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [22:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [24:0] avm_address;
  logic avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0] avm_byteenable;
  logic avm_waitrequest = 0, avm_readdatavalid = 0;
  logic [31:0] avm_readdata = '0;

  typedef struct {logic [31:0] rdata; logic err; bit chk_rd; int acc; int lat;} rsp_t;
  typedef struct {logic write; logic [24:0] addr; logic [31:0] wdata; logic [3:0] be; int stall; int lat;} cmd_t;
  typedef struct {int due; logic [31:0] data;} beat_t;
  rsp_t rq[$];
  cmd_t cq[$];
  beat_t pend[$];
  logic [31:0] mem [int];
  int checks = 0, errors = 0, cyc = 0, cmd_cnt = 0;
  bit spurious = 0, chk_rdy = 0;

  lua_avalon_mem_master #(.ADDR_W(23), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // slave: stalls each command cq[0].stall cycles, returns read beats cq[0].lat cycles after acceptance
  always @(negedge clk_clk) begin
    avm_readdatavalid = 0;
    if (spurious) begin
      avm_readdatavalid = 1;
      avm_readdata = 32'hFFFF_FFFF;
      spurious = 0;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      avm_readdatavalid = 1;
      avm_readdata = pend.pop_front().data;
    end
    if (avm_read || avm_write) begin
      if (cq.size() == 0) chk("cmd_unexpected", 32'(avm_read || avm_write), 0);
      else begin
        chk("cmd_write", 32'(avm_write), 32'(cq[0].write));
        chk("cmd_read", 32'(avm_read), 32'(!cq[0].write));
        chk("cmd_addr", 32'(avm_address), 32'(cq[0].addr));
        chk("cmd_be", 32'(avm_byteenable), 32'(cq[0].be));
        if (cq[0].write) chk("cmd_wdata", avm_writedata, cq[0].wdata);
        avm_waitrequest = cmd_cnt < cq[0].stall;
        if (avm_waitrequest) cmd_cnt++;
        else begin
          cmd_cnt = 0;
          if (avm_write) begin
            for (int b = 0; b < 4; b++)
              if (avm_byteenable[b]) begin
                if (!mem.exists(int'(avm_address))) mem[int'(avm_address)] = '0;
                mem[int'(avm_address)][8*b +: 8] = avm_writedata[8*b +: 8];
              end
          end else
            pend.push_back('{cyc + cq[0].lat, mem.exists(int'(avm_address)) ? mem[int'(avm_address)] : 32'h0});
          void'(cq.pop_front());
        end
      end
    end else begin
      cmd_cnt = 0;
      avm_waitrequest = 0;
    end
  end

  always @(negedge clk_clk) begin
    if (chk_rdy) chk("ready_after_rsp", 32'(req_ready), 1);
    chk_rdy = 0;
    if (reset_reset_n && rsp_valid) begin
      chk_rdy = 1;
      if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        rsp_t e;
        e = rq.pop_front();
        if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", cyc - e.acc, e.lat);
        chk("ready_low_at_rsp", 32'(req_ready), 0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [22:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int stall, input int lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input bit want_rsp);
    int n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 1);
    cq.push_back('{w, {a, 2'b00}, d, w ? be : 4'hF, stall, lat});
    if (want_rsp) rq.push_back('{exp_rd, exp_err, !w, cyc + 1, exp_lat});
    @(negedge clk_clk);
    req_valid = 0;
  endtask

  initial begin
    logic [31:0] wd [4];
    int n;
    wd = '{32'h1111_2222, 32'hA5A5_5A5A, 32'h0BAD_F00D, 32'h7654_3210};
    repeat (2) @(negedge clk_clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_avm_read", 32'(avm_read), 0);
    chk("rst_avm_write", 32'(avm_write), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_avm_address", 32'(avm_address), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    reset_reset_n = 1;
    repeat (2) @(negedge clk_clk);
    do_req(1, 23'h10, 32'hCAFE_F00D, 4'b0011, 0, 1, 0, 0, 2, 1);
    repeat (4) @(negedge clk_clk);
    mem[32'h48C] = 32'h1234_5678;
    do_req(0, 23'h123, 0, 4'h0, 3, 2, 32'h1234_5678, 0, 7, 1);
    repeat (10) @(negedge clk_clk);
    for (int i = 0; i < 4; i++) begin
      do_req(1, 23'h55, wd[i], 4'hF, 0, 1, 0, 0, 2, 1);
      do_req(0, 23'h55, 0, 4'h0, 0, 1, wd[i], 0, 3, 1);
    end
    repeat (6) @(negedge clk_clk);
    spurious = 1;
    repeat (5) @(negedge clk_clk);
    do_req(0, 23'h55, 0, 4'h0, 0, 1, wd[3], 0, 3, 1);
    repeat (6) @(negedge clk_clk);
    do_req(0, 23'h77, 0, 4'h0, 100, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk_clk);
    #2 reset_reset_n = 0;
    #1 chk("rst_mid_avm_read", 32'(avm_read), 0);
    chk("rst_mid_req_ready", 32'(req_ready), 1);
    cq.delete();
    @(negedge clk_clk);
    reset_reset_n = 1;
    repeat (10) @(negedge clk_clk);
    chk("post_rst_ready", 32'(req_ready), 1);
`ifdef LUA_AVM_TIMEOUT_EN
    mem[32'h800] = 32'hBAD0_BAD0;
    mem[32'h804] = 32'h0600_D000;
    do_req(0, 23'h200, 0, 4'h0, 0, 22, 32'hDEAD_BEEF, 1, 18, 1);
    do_req(0, 23'h201, 0, 4'h0, 0, 3, 32'h0600_D000, 0, 5, 1);
`endif
    n = 0;
    while (rq.size() > 0 && n < 500) begin
      @(negedge clk_clk);
      n++;
    end
    chk("rsp_drain", rq.size(), 0);
    repeat (3) @(negedge clk_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
